// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: holds issued ops until both operands are known,
// snoops the ALU and LSB result buses, and dispatches one ready op per cycle.
module alu_rs #(
    parameter int unsigned RS_SIZE = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned OP_W    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              in_clear,
    input  logic              in_issue_valid,
    input  logic [OP_W-1:0]   in_issue_op,
    input  logic              in_issue_q1_rdy,
    input  logic [DATA_W-1:0] in_issue_v1,
    input  logic [TAG_W-1:0]  in_issue_q1,
    input  logic              in_issue_q2_rdy,
    input  logic [DATA_W-1:0] in_issue_v2,
    input  logic [TAG_W-1:0]  in_issue_q2,
    input  logic [DATA_W-1:0] in_issue_imm,
    input  logic [DATA_W-1:0] in_issue_pc,
    input  logic [TAG_W-1:0]  in_issue_reorder,
    output logic              out_full,
    input  logic              in_alu_cdb_valid,
    input  logic [TAG_W-1:0]  in_alu_cdb_tag,
    input  logic [DATA_W-1:0] in_alu_cdb_value,
    input  logic              in_lsb_cdb_valid,
    input  logic [TAG_W-1:0]  in_lsb_cdb_tag,
    input  logic [DATA_W-1:0] in_lsb_cdb_value,
    output logic              out_alu_valid,
    output logic [OP_W-1:0]   out_alu_op,
    output logic [DATA_W-1:0] out_alu_rs1,
    output logic [DATA_W-1:0] out_alu_rs2,
    output logic [DATA_W-1:0] out_alu_imm,
    output logic [DATA_W-1:0] out_alu_pc,
    output logic [TAG_W-1:0]  out_alu_reorder
);

    localparam int unsigned IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] r_busy;
    logic [RS_SIZE-1:0] r_q1_rdy;
    logic [RS_SIZE-1:0] r_q2_rdy;
    logic [OP_W-1:0]    r_op      [RS_SIZE];
    logic [DATA_W-1:0]  r_v1      [RS_SIZE];
    logic [TAG_W-1:0]   r_q1      [RS_SIZE];
    logic [DATA_W-1:0]  r_v2      [RS_SIZE];
    logic [TAG_W-1:0]   r_q2      [RS_SIZE];
    logic [DATA_W-1:0]  r_imm     [RS_SIZE];
    logic [DATA_W-1:0]  r_pc      [RS_SIZE];
    logic [TAG_W-1:0]   r_reorder [RS_SIZE];

    logic               r_alu_valid;
    logic [OP_W-1:0]    r_alu_op;
    logic [DATA_W-1:0]  r_alu_rs1;
    logic [DATA_W-1:0]  r_alu_rs2;
    logic [DATA_W-1:0]  r_alu_imm;
    logic [DATA_W-1:0]  r_alu_pc;
    logic [TAG_W-1:0]   r_alu_reorder;

    logic               w_has_free;
    logic [IDX_W-1:0]   w_free_idx;
    logic               w_has_sel;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [RS_SIZE-1:0] w_ready;
    logic [DATA_W:0]    w_op1_nxt [RS_SIZE];
    logic [DATA_W:0]    w_op2_nxt [RS_SIZE];
    logic [DATA_W:0]    w_iss_op1;
    logic [DATA_W:0]    w_iss_op2;

    // Returns {ready, value}; a pending operand is resolved from the CDBs, ALU bus first.
    function automatic logic [DATA_W:0] fwd(input logic             f_rdy,
                                            input logic [DATA_W-1:0] f_val,
                                            input logic [TAG_W-1:0]  f_tag);
        if (f_rdy) begin
            return {1'b1, f_val};
        end else if (in_alu_cdb_valid && (in_alu_cdb_tag == f_tag)) begin
            return {1'b1, in_alu_cdb_value};
        end else if (in_lsb_cdb_valid && (in_lsb_cdb_tag == f_tag)) begin
            return {1'b1, in_lsb_cdb_value};
        end
        return {1'b0, f_val};
    endfunction

    assign out_full  = &r_busy;
    assign w_ready   = r_busy & r_q1_rdy & r_q2_rdy;
    assign w_iss_op1 = fwd(in_issue_q1_rdy, in_issue_v1, in_issue_q1);
    assign w_iss_op2 = fwd(in_issue_q2_rdy, in_issue_v2, in_issue_q2);

    // Both encoders scan downward so the lowest index wins.
    always_comb begin
        w_has_free = 1'b0;
        w_free_idx = '0;
        w_has_sel  = 1'b0;
        w_sel_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_has_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            if (w_ready[i]) begin
                w_has_sel = 1'b1;
                w_sel_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_op1_nxt[i] = fwd(r_q1_rdy[i], r_v1[i], r_q1[i]);
            w_op2_nxt[i] = fwd(r_q2_rdy[i], r_v2[i], r_q2[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy        <= '0;
            r_q1_rdy      <= '0;
            r_q2_rdy      <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_op[i]      <= '0;
                r_v1[i]      <= '0;
                r_q1[i]      <= '0;
                r_v2[i]      <= '0;
                r_q2[i]      <= '0;
                r_imm[i]     <= '0;
                r_pc[i]      <= '0;
                r_reorder[i] <= '0;
            end
            r_alu_valid   <= 1'b0;
            r_alu_op      <= '0;
            r_alu_rs1     <= '0;
            r_alu_rs2     <= '0;
            r_alu_imm     <= '0;
            r_alu_pc      <= '0;
            r_alu_reorder <= '0;
        end else if (rdy) begin
            if (in_clear) begin
                r_busy      <= '0;
                r_alu_valid <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (r_busy[i]) begin
                        {r_q1_rdy[i], r_v1[i]} <= w_op1_nxt[i];
                        {r_q2_rdy[i], r_v2[i]} <= w_op2_nxt[i];
                    end
                end
                if (w_has_sel) begin
                    r_busy[w_sel_idx] <= 1'b0;
                    r_alu_valid       <= 1'b1;
                    r_alu_op          <= r_op[w_sel_idx];
                    r_alu_rs1         <= r_v1[w_sel_idx];
                    r_alu_rs2         <= r_v2[w_sel_idx];
                    r_alu_imm         <= r_imm[w_sel_idx];
                    r_alu_pc          <= r_pc[w_sel_idx];
                    r_alu_reorder     <= r_reorder[w_sel_idx];
                end else begin
                    r_alu_valid <= 1'b0;
                end
                // A free slot is never the selected one, so issue and dispatch never collide.
                if (in_issue_valid && w_has_free) begin
                    r_busy[w_free_idx]                   <= 1'b1;
                    r_op[w_free_idx]                     <= in_issue_op;
                    {r_q1_rdy[w_free_idx], r_v1[w_free_idx]} <= w_iss_op1;
                    {r_q2_rdy[w_free_idx], r_v2[w_free_idx]} <= w_iss_op2;
                    r_q1[w_free_idx]                     <= in_issue_q1;
                    r_q2[w_free_idx]                     <= in_issue_q2;
                    r_imm[w_free_idx]                    <= in_issue_imm;
                    r_pc[w_free_idx]                     <= in_issue_pc;
                    r_reorder[w_free_idx]                <= in_issue_reorder;
                end
            end
        end
    end

    assign out_alu_valid   = r_alu_valid;
    assign out_alu_op      = r_alu_op;
    assign out_alu_rs1     = r_alu_rs1;
    assign out_alu_rs2     = r_alu_rs2;
    assign out_alu_imm     = r_alu_imm;
    assign out_alu_pc      = r_alu_pc;
    assign out_alu_reorder = r_alu_reorder;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus a randomized run against a
// queue-level reference model of the reservation station.
module tb_alu_rs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        in_clear = 1'b0;
    logic        in_issue_valid = 1'b0;
    logic [5:0]  in_issue_op = '0;
    logic        in_issue_q1_rdy = 1'b0;
    logic [31:0] in_issue_v1 = '0;
    logic [3:0]  in_issue_q1 = '0;
    logic        in_issue_q2_rdy = 1'b0;
    logic [31:0] in_issue_v2 = '0;
    logic [3:0]  in_issue_q2 = '0;
    logic [31:0] in_issue_imm = '0;
    logic [31:0] in_issue_pc = '0;
    logic [3:0]  in_issue_reorder = '0;
    logic        out_full;
    logic        in_alu_cdb_valid = 1'b0;
    logic [3:0]  in_alu_cdb_tag = '0;
    logic [31:0] in_alu_cdb_value = '0;
    logic        in_lsb_cdb_valid = 1'b0;
    logic [3:0]  in_lsb_cdb_tag = '0;
    logic [31:0] in_lsb_cdb_value = '0;
    logic        out_alu_valid;
    logic [5:0]  out_alu_op;
    logic [31:0] out_alu_rs1, out_alu_rs2, out_alu_imm, out_alu_pc;
    logic [3:0]  out_alu_reorder;

    int total = 0;
    int bad = 0;

    alu_rs dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .in_clear(in_clear),
        .in_issue_valid(in_issue_valid), .in_issue_op(in_issue_op),
        .in_issue_q1_rdy(in_issue_q1_rdy), .in_issue_v1(in_issue_v1), .in_issue_q1(in_issue_q1),
        .in_issue_q2_rdy(in_issue_q2_rdy), .in_issue_v2(in_issue_v2), .in_issue_q2(in_issue_q2),
        .in_issue_imm(in_issue_imm), .in_issue_pc(in_issue_pc),
        .in_issue_reorder(in_issue_reorder), .out_full(out_full),
        .in_alu_cdb_valid(in_alu_cdb_valid), .in_alu_cdb_tag(in_alu_cdb_tag),
        .in_alu_cdb_value(in_alu_cdb_value), .in_lsb_cdb_valid(in_lsb_cdb_valid),
        .in_lsb_cdb_tag(in_lsb_cdb_tag), .in_lsb_cdb_value(in_lsb_cdb_value),
        .out_alu_valid(out_alu_valid), .out_alu_op(out_alu_op), .out_alu_rs1(out_alu_rs1),
        .out_alu_rs2(out_alu_rs2), .out_alu_imm(out_alu_imm), .out_alu_pc(out_alu_pc),
        .out_alu_reorder(out_alu_reorder)
    );

    always #5 clk = ~clk;

    // Reference model: a slot table scanned with plain loops.
    typedef struct {
        bit        busy;
        bit [5:0]  op;
        bit        r1;
        bit [31:0] v1;
        bit [3:0]  q1;
        bit        r2;
        bit [31:0] v2;
        bit [3:0]  q2;
        bit [31:0] imm;
        bit [31:0] pc;
        bit [3:0]  rob;
    } ent_t;

    ent_t      m_e [16];
    bit        m_valid;
    bit [5:0]  m_op;
    bit [31:0] m_rs1, m_rs2, m_imm, m_pc;
    bit [3:0]  m_rob;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_clear = 1'b0;
        in_issue_valid = 1'b0;
        in_alu_cdb_valid = 1'b0;
        in_lsb_cdb_valid = 1'b0;
    endtask

    task automatic set_issue(input bit [5:0] op, input bit r1, input bit [31:0] v1,
                             input bit [3:0] q1, input bit r2, input bit [31:0] v2,
                             input bit [3:0] q2, input bit [31:0] imm, input bit [3:0] rob);
        in_issue_valid = 1'b1;
        in_issue_op = op;
        in_issue_q1_rdy = r1;
        in_issue_v1 = v1;
        in_issue_q1 = q1;
        in_issue_q2_rdy = r2;
        in_issue_v2 = v2;
        in_issue_q2 = q2;
        in_issue_imm = imm;
        in_issue_pc = imm + 32'h1000;
        in_issue_reorder = rob;
    endtask

    function automatic bit [32:0] resolve(input bit r, input bit [31:0] v, input bit [3:0] q);
        if (r) return {1'b1, v};
        if (in_alu_cdb_valid && in_alu_cdb_tag == q) return {1'b1, in_alu_cdb_value};
        if (in_lsb_cdb_valid && in_lsb_cdb_tag == q) return {1'b1, in_lsb_cdb_value};
        return {1'b0, v};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_e[i].busy = 1'b0;
        m_valid = 0; m_op = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_pc = 0; m_rob = 0;
    endtask

    function automatic bit model_full();
        for (int i = 0; i < 16; i++) if (!m_e[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int sel = -1;
        int fr = -1;
        ent_t nx [16];
        if (!rdy) return;
        if (in_clear) begin
            for (int i = 0; i < 16; i++) m_e[i].busy = 1'b0;
            m_valid = 0;
            return;
        end
        for (int i = 15; i >= 0; i--) begin
            if (m_e[i].busy && m_e[i].r1 && m_e[i].r2) sel = i;
            if (!m_e[i].busy) fr = i;
        end
        nx = m_e;
        for (int i = 0; i < 16; i++) begin
            if (m_e[i].busy) begin
                {nx[i].r1, nx[i].v1} = resolve(m_e[i].r1, m_e[i].v1, m_e[i].q1);
                {nx[i].r2, nx[i].v2} = resolve(m_e[i].r2, m_e[i].v2, m_e[i].q2);
            end
        end
        if (sel >= 0) begin
            m_valid = 1; m_op = m_e[sel].op; m_rs1 = m_e[sel].v1; m_rs2 = m_e[sel].v2;
            m_imm = m_e[sel].imm; m_pc = m_e[sel].pc; m_rob = m_e[sel].rob;
            nx[sel].busy = 1'b0;
        end else begin
            m_valid = 0;
        end
        if (in_issue_valid && fr >= 0) begin
            nx[fr].busy = 1'b1;
            nx[fr].op = in_issue_op;
            {nx[fr].r1, nx[fr].v1} = resolve(in_issue_q1_rdy, in_issue_v1, in_issue_q1);
            {nx[fr].r2, nx[fr].v2} = resolve(in_issue_q2_rdy, in_issue_v2, in_issue_q2);
            nx[fr].q1 = in_issue_q1;
            nx[fr].q2 = in_issue_q2;
            nx[fr].imm = in_issue_imm;
            nx[fr].pc = in_issue_pc;
            nx[fr].rob = in_issue_reorder;
        end
        m_e = nx;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if (out_alu_valid !== 1'b0 || out_full !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl: valid=%b full=%b want 0 0", out_alu_valid, out_full);
        end
        total++;
        if ({out_alu_op, out_alu_rs1, out_alu_rs2, out_alu_imm, out_alu_pc, out_alu_reorder}
            !== '0) begin
            bad++;
            $display("FAIL reset_data: rs1=%h imm=%h rob=%h want 0", out_alu_rs1, out_alu_imm,
                     out_alu_reorder);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        set_issue(6'd3, 1, 32'd5, 4'd0, 1, 32'd0, 4'd0, 32'd7, 4'd3);
        tick();
        idle();
        total++;
        if (out_alu_valid !== 1'b0 || out_full !== 1'b0) begin
            bad++;
            $display("FAIL basic_early: valid=%b full=%b want 0 0", out_alu_valid, out_full);
        end
        tick();
        total++;
        if (out_alu_valid !== 1'b1 || out_alu_rs1 !== 32'd5 || out_alu_imm !== 32'd7 ||
            out_alu_reorder !== 4'd3 || out_full !== 1'b0) begin
            bad++;
            $display("FAIL basic_dispatch: valid=%b rs1=%h imm=%h rob=%h full=%b want 1 5 7 3 0",
                     out_alu_valid, out_alu_rs1, out_alu_imm, out_alu_reorder, out_full);
        end
        tick();
        total++;
        if (out_alu_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_once: valid=%b want 0", out_alu_valid);
        end
    endtask

    task automatic test_wakeup();
        set_issue(6'd1, 0, 32'd0, 4'd2, 1, 32'd1, 4'd0, 32'd0, 4'd4);
        tick();
        idle();
        tick();
        in_alu_cdb_valid = 1'b1;
        in_alu_cdb_tag = 4'd2;
        in_alu_cdb_value = 32'h10;
        total++;
        if (out_alu_valid !== 1'b0) begin
            bad++;
            $display("FAIL wake_waiting: valid=%b want 0", out_alu_valid);
        end
        tick();
        idle();
        total++;
        if (out_alu_valid !== 1'b0) begin
            bad++;
            $display("FAIL wake_same_cycle: valid=%b want 0", out_alu_valid);
        end
        tick();
        total++;
        if (out_alu_valid !== 1'b1 || out_alu_rs1 !== 32'h10 || out_alu_rs2 !== 32'd1) begin
            bad++;
            $display("FAIL wake_dispatch: valid=%b rs1=%h rs2=%h want 1 10 1", out_alu_valid,
                     out_alu_rs1, out_alu_rs2);
        end
        tick();
    endtask

    task automatic test_forward();
        set_issue(6'd2, 1, 32'd3, 4'd0, 0, 32'd0, 4'd6, 32'd0, 4'd5);
        in_lsb_cdb_valid = 1'b1;
        in_lsb_cdb_tag = 4'd6;
        in_lsb_cdb_value = 32'hABCD;
        tick();
        idle();
        tick();
        total++;
        if (out_alu_valid !== 1'b1 || out_alu_rs2 !== 32'hABCD || out_alu_rs1 !== 32'd3) begin
            bad++;
            $display("FAIL forward: valid=%b rs1=%h rs2=%h want 1 3 abcd", out_alu_valid,
                     out_alu_rs1, out_alu_rs2);
        end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            set_issue(6'd1, 0, 32'd0, 4'd9, 1, i, 4'd0, 32'd100 + i, 4'(i));
            tick();
        end
        total++;
        if (out_full !== 1'b1) begin
            bad++;
            $display("FAIL full_set: full=%b want 1", out_full);
        end
        set_issue(6'd7, 1, 32'd1, 4'd0, 1, 32'd2, 4'd0, 32'd999, 4'd0);
        tick();
        idle();
        total++;
        if (out_full !== 1'b1 || out_alu_valid !== 1'b0) begin
            bad++;
            $display("FAIL full_drop: full=%b valid=%b want 1 0", out_full, out_alu_valid);
        end
        in_alu_cdb_valid = 1'b1;
        in_alu_cdb_tag = 4'd9;
        in_alu_cdb_value = 32'h99;
        tick();
        idle();
        for (int k = 0; k < 16; k++) begin
            tick();
            total++;
            if (out_alu_valid !== 1'b1 || out_alu_imm !== 32'd100 + k || out_alu_rs1 !== 32'h99
                || (k == 0 && out_full !== 1'b0)) begin
                bad++;
                $display("FAIL full_drain[%0d]: valid=%b imm=%0d rs1=%h full=%b want 1 %0d 99",
                         k, out_alu_valid, out_alu_imm, out_alu_rs1, out_full, 100 + k);
            end
        end
        tick();
        total++;
        if (out_alu_valid !== 1'b0 || out_full !== 1'b0) begin
            bad++;
            $display("FAIL full_end: valid=%b full=%b want 0 0", out_alu_valid, out_full);
        end
    endtask

    task automatic test_clear();
        int seen = 0;
        set_issue(6'd1, 0, 32'd0, 4'd5, 1, 32'd0, 4'd0, 32'd1, 4'd1);
        tick();
        set_issue(6'd1, 0, 32'd0, 4'd5, 1, 32'd0, 4'd0, 32'd2, 4'd2);
        tick();
        set_issue(6'd1, 1, 32'd0, 4'd0, 1, 32'd0, 4'd0, 32'd3, 4'd3);
        tick();
        set_issue(6'd1, 1, 32'd0, 4'd0, 1, 32'd0, 4'd0, 32'd4, 4'd4);
        in_clear = 1'b1;
        tick();
        idle();
        total++;
        if (out_alu_valid !== 1'b0 || out_full !== 1'b0) begin
            bad++;
            $display("FAIL clear_now: valid=%b full=%b want 0 0", out_alu_valid, out_full);
        end
        in_alu_cdb_valid = 1'b1;
        in_alu_cdb_tag = 4'd5;
        tick();
        idle();
        if (out_alu_valid) seen++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_alu_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL clear_later: dispatches=%0d want 0", seen);
        end
    endtask

    task automatic test_hold();
        set_issue(6'd1, 1, 32'hA1, 4'd0, 1, 32'd0, 4'd0, 32'd0, 4'd1);
        tick();
        set_issue(6'd1, 1, 32'hB2, 4'd0, 1, 32'd0, 4'd0, 32'd0, 4'd2);
        tick();
        idle();
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (out_alu_valid !== 1'b1 || out_alu_rs1 !== 32'hA1 || out_alu_reorder !== 4'd1) begin
                bad++;
                $display("FAIL hold_frozen[%0d]: valid=%b rs1=%h want 1 a1", i, out_alu_valid,
                         out_alu_rs1);
            end
        end
        rdy = 1'b1;
        tick();
        total++;
        if (out_alu_valid !== 1'b1 || out_alu_rs1 !== 32'hB2) begin
            bad++;
            $display("FAIL hold_release: valid=%b rs1=%h want 1 b2", out_alu_valid, out_alu_rs1);
        end
        tick();
        total++;
        if (out_alu_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_once: valid=%b want 0", out_alu_valid);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        set_issue(6'd1, 1, 32'h11, 4'd0, 1, 32'd0, 4'd0, 32'd0, 4'd1);
        tick();
        set_issue(6'd1, 1, 32'h22, 4'd0, 1, 32'd0, 4'd0, 32'd0, 4'd2);
        tick();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_alu_valid !== 1'b0 || out_alu_rs1 !== 32'd0 || out_full !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: valid=%b rs1=%h full=%b want 0 0 0", out_alu_valid,
                     out_alu_rs1, out_full);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_alu_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL reset_mid_after: dispatches=%0d want 0", seen);
        end
    endtask

    task automatic test_random();
        model_reset();
        for (int c = 0; c < 800; c++) begin
            rdy = ($urandom_range(0, 7) != 0);
            in_clear = ($urandom_range(0, 59) == 0);
            in_issue_valid = ($urandom_range(0, 2) != 0);
            in_issue_op = 6'($urandom);
            in_issue_q1_rdy = 1'($urandom_range(0, 1));
            in_issue_v1 = $urandom;
            in_issue_q1 = 4'($urandom_range(0, 7));
            in_issue_q2_rdy = 1'($urandom_range(0, 1));
            in_issue_v2 = $urandom;
            in_issue_q2 = 4'($urandom_range(0, 7));
            in_issue_imm = $urandom;
            in_issue_pc = $urandom;
            in_issue_reorder = 4'($urandom);
            in_alu_cdb_valid = 1'($urandom_range(0, 1));
            in_alu_cdb_tag = 4'($urandom_range(0, 7));
            in_alu_cdb_value = $urandom;
            in_lsb_cdb_valid = 1'($urandom_range(0, 1));
            in_lsb_cdb_tag = 4'($urandom_range(0, 7));
            in_lsb_cdb_value = $urandom;
            total++;
            if (out_full !== model_full()) begin
                bad++;
                $display("FAIL rand_full[%0d]: got %b want %b", c, out_full, model_full());
            end
            model_step();
            tick();
            total++;
            if ({out_alu_valid, out_alu_op, out_alu_rs1, out_alu_rs2, out_alu_imm, out_alu_pc,
                 out_alu_reorder} !== {m_valid, m_op, m_rs1, m_rs2, m_imm, m_pc, m_rob}) begin
                bad++;
                $display("FAIL rand_out[%0d]: got v=%b op=%h rs1=%h rs2=%h imm=%h pc=%h rob=%h want v=%b op=%h rs1=%h rs2=%h imm=%h pc=%h rob=%h",
                         c, out_alu_valid, out_alu_op, out_alu_rs1, out_alu_rs2, out_alu_imm,
                         out_alu_pc, out_alu_reorder, m_valid, m_op, m_rs1, m_rs2, m_imm, m_pc,
                         m_rob);
            end
        end
        idle();
        rdy = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_forward();
        test_full();
        test_clear();
        test_hold();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
